// File: rtl/trax_move_tx.sv
// TRAX move transmitter: converts a {type,row,col} move into ASCII TRAX notation and sends it as 8N1 UART.
// Optional TRAX_TX_NEWLINE_EN appends '\n' to every move (buffer depth 7 instead of 6).
module trax_move_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [21:0] move_in,
  input  logic        start_transmit,
  output logic        tx,
  output logic        busy,
  output logic        end_transmit,
  output logic        err
);

`ifdef TRAX_TX_NEWLINE_EN
  localparam int DEPTH = 7;
`else
  localparam int DEPTH = 6;
`endif

  localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] CONVERT = 3'd2;
  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] STOP    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]       state;
  logic [1:0]       mv_type;
  logic [9:0]       mv_row;
  logic [9:0]       mv_col;

  logic [9:0]       row_rem;
  logic [9:0]       col_rem;
  logic [3:0]       hund;
  logic [3:0]       tens;
  logic [4:0]       col_hi;
  logic             col_zero;
  logic [1:0]       row_phase;

  logic [7:0]       char_buf [DEPTH];
  logic [7:0]       fill     [DEPTH];
  logic [2:0]       nchar;
  logic [2:0]       char_cnt;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;

  logic             mv_valid;
  logic             conv_done;
  logic             bit_end;

  assign mv_valid  = (mv_col <= 10'd702) && (mv_row <= 10'd999) && (mv_type != 2'd3);
  assign conv_done = (row_phase == 2'd2) && (col_rem < 10'd26);
  assign bit_end   = (clk_cnt == BIT_LAST);

  // Packs letters, digits, tile (and newline) from the finished conversion registers.
  always_comb begin
    logic [2:0] idx;
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    fill = '{default: 8'h00};
    idx  = 3'd0;
    // NOTE: blocking assignments here so each step sees the index updated just above.
    if (col_zero) begin
      fill[idx] = 8'h40;
      idx       = idx + 3'd1;
    end else if (col_hi == 5'd0) begin
      fill[idx] = 8'h41 + {3'b000, col_rem[4:0]};
      idx       = idx + 3'd1;
    end else begin
      fill[idx] = 8'h40 + {3'b000, col_hi};
      idx       = idx + 3'd1;
      fill[idx] = 8'h41 + {3'b000, col_rem[4:0]};
      idx       = idx + 3'd1;
    end
    if (hund != 4'd0) begin
      fill[idx] = 8'h30 + {4'h0, hund};
      idx       = idx + 3'd1;
    end
    if ((hund != 4'd0) || (tens != 4'd0)) begin
      fill[idx] = 8'h30 + {4'h0, tens};
      idx       = idx + 3'd1;
    end
    fill[idx] = 8'h30 + {4'h0, row_rem[3:0]};
    idx       = idx + 3'd1;
    case (mv_type)
      2'd0:    fill[idx] = 8'h2B;
      2'd1:    fill[idx] = 8'h2F;
      default: fill[idx] = 8'h5C;
    endcase
    idx = idx + 3'd1;
`ifdef TRAX_TX_NEWLINE_EN
    fill[idx] = 8'h0A;
    idx       = idx + 3'd1;
`endif
    nchar = idx;
  end

  // NOTE: only control state is reset; the character buffer and datapath registers
  // are always written before they are read, so they carry no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      busy         <= 1'b0;
      end_transmit <= 1'b0;
      err          <= 1'b0;
      char_cnt     <= 3'd0;
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
    end else begin
      end_transmit <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start_transmit && !busy) begin
            {mv_type, mv_row, mv_col} <= move_in;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!mv_valid) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            row_rem   <= mv_row;
            col_rem   <= (mv_col == 10'd0) ? 10'd0 : mv_col - 10'd1;
            col_zero  <= (mv_col == 10'd0);
            hund      <= 4'd0;
            tens      <= 4'd0;
            col_hi    <= 5'd0;
            row_phase <= 2'd0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            char_buf  <= fill;
            char_cnt  <= nchar;
            shift_reg <= fill[0];
            tx        <= 1'b0;
            clk_cnt   <= '0;
            state     <= START;
          end else begin
            // Row digits are peeled sequentially; the column runs in parallel,
            // stepping by 260 first to keep the worst case near 20 cycles.
            case (row_phase)
              2'd0: begin
                if (row_rem >= 10'd100) begin
                  row_rem <= row_rem - 10'd100;
                  hund    <= hund + 4'd1;
                end else begin
                  row_phase <= 2'd1;
                end
              end
              2'd1: begin
                if (row_rem >= 10'd10) begin
                  row_rem <= row_rem - 10'd10;
                  tens    <= tens + 4'd1;
                end else begin
                  row_phase <= 2'd2;
                end
              end
              default: ;
            endcase
            if (col_rem >= 10'd260) begin
              col_rem <= col_rem - 10'd260;
              col_hi  <= col_hi + 5'd10;
            end else if (col_rem >= 10'd26) begin
              col_rem <= col_rem - 10'd26;
              col_hi  <= col_hi + 5'd1;
            end
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shift_reg[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx        <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (char_cnt > 3'd1) begin
              char_cnt  <= char_cnt - 3'd1;
              shift_reg <= char_buf[1];
              for (int i = 0; i < DEPTH - 1; i++) char_buf[i] <= char_buf[i+1];
              tx        <= 1'b0;
              state     <= START;
            end else begin
              char_cnt <= 3'd0;
              state    <= DONE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          end_transmit <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trax_move_tx.sv
// Directed bench for trax_move_tx: decodes the UART line sample by sample against hand-computed frames.
module tb_trax_move_tx;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [21:0] move_in;
  logic        start_transmit;
  logic        tx;
  logic        busy;
  logic        end_transmit;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  trax_move_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .move_in        (move_in),
    .start_transmit (start_transmit),
    .tx             (tx),
    .busy           (busy),
    .end_transmit   (end_transmit),
    .err            (err)
  );

  function automatic logic [21:0] mv(input int t, input int r, input int c);
    return {t[1:0], r[9:0], c[9:0]};
  endfunction

  task automatic add_newline();
`ifdef TRAX_TX_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic send(input logic [21:0] m, input string name);
    @(negedge clock);
    move_in        = m;
    start_transmit = 1'b1;
    @(negedge clock);
    start_transmit = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_busy: busy=%b required 1", name, busy);
    end
  endtask

  // Samples every cycle of the frame: bytes, exact bit widths, busy and the end pulse.
  task automatic rx_frame(input string name);
    int n, t, bad, busy_bad, end_bad, ecount;
    logic [9:0] want, got;
    n = exp_q.size();
    t = 0; busy_bad = 0; end_bad = 0; ecount = 0;
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start_bit_timeout: tx=%b required 0", name, tx);
      return;
    end
    for (int i = 0; i < n; i++) begin
      want = {1'b1, exp_q[i], 1'b0};
      got  = '0;
      bad  = 0;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (k == CPB / 2) got[b] = tx;
          if (tx !== want[b]) bad++;
          if (busy !== 1'b1) busy_bad++;
          if (end_transmit !== 1'b0) end_bad++;
          @(negedge clock);
        end
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s byte%0d: frame=%b required %b (char 0x%02h)", name, i, got, want, exp_q[i]);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s byte%0d_timing: %0d off samples required 0", name, i, bad);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_during_frame: %0d low samples required 0", name, busy_bad);
    end
    checks++;
    if (end_bad != 0) begin
      errors++;
      $display("FAIL %s early_end_transmit: %0d high samples required 0", name, end_bad);
    end
    for (int w = 0; w < 6; w++) begin
      if (end_transmit === 1'b1) ecount++;
      @(negedge clock);
    end
    checks++;
    if (ecount != 1) begin
      errors++;
      $display("FAIL %s end_pulse_count: %0d required 1", name, ecount);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: tx=%b busy=%b required 1 0", name, tx, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_transmit = 1'b0; move_in = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx, busy, end_transmit, err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: tx,busy,end,err=%b required 1000", {tx, busy, end_transmit, err});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx, busy, end_transmit, err} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_idle: tx,busy,end,err=%b required 1000", {tx, busy, end_transmit, err});
    end
  endtask

  task automatic test_encode();
    exp_q = '{8'h41, 8'h31, 8'h2B}; add_newline();
    send(mv(0, 1, 1), "basic"); rx_frame("basic");
    exp_q = '{8'h40, 8'h30, 8'h5C}; add_newline();
    send(mv(2, 0, 0), "zero"); rx_frame("zero");
    exp_q = '{8'h41, 8'h41, 8'h31, 8'h30, 8'h35, 8'h2F}; add_newline();
    send(mv(1, 105, 27), "aa105"); rx_frame("aa105");
    exp_q = '{8'h5A, 8'h5A, 8'h39, 8'h39, 8'h39, 8'h2B}; add_newline();
    send(mv(0, 999, 702), "zz999"); rx_frame("zz999");
    exp_q = '{8'h41, 8'h5A, 8'h31, 8'h30, 8'h2F}; add_newline();
    send(mv(1, 10, 52), "az10"); rx_frame("az10");
    exp_q = '{8'h42, 8'h41, 8'h39, 8'h39, 8'h5C}; add_newline();
    send(mv(2, 99, 53), "ba99"); rx_frame("ba99");
    exp_q = '{8'h5A, 8'h37, 8'h2B}; add_newline();
    send(mv(0, 7, 26), "z7"); rx_frame("z7");
  endtask

  task automatic test_reject(input logic [21:0] m, input string name);
    int ecount, first, tx_bad, end_bad;
    ecount = 0; first = -1; tx_bad = 0; end_bad = 0;
    send(m, name);
    for (int w = 0; w < 20; w++) begin
      if (err === 1'b1) begin
        ecount++;
        if (first < 0) first = w;
      end
      if (tx !== 1'b1) tx_bad++;
      if (end_transmit !== 1'b0) end_bad++;
      @(negedge clock);
    end
    checks++;
    if (ecount != 1 || first < 0 || first > 1) begin
      errors++;
      $display("FAIL %s err_pulse: count=%0d at=%0d required 1 at <=1", name, ecount, first);
    end
    checks++;
    if (tx_bad != 0 || end_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s quiet_line: tx_low=%0d end=%0d busy=%b required 0 0 0", name, tx_bad, end_bad, busy);
    end
  endtask

  task automatic test_ignore_mid_frame();
    int tx_bad;
    tx_bad = 0;
    exp_q = '{8'h41, 8'h31, 8'h2B}; add_newline();
    send(mv(0, 1, 1), "ignore");
    fork
      rx_frame("ignore");
      begin
        repeat (40) @(negedge clock);
        move_in        = mv(1, 999, 702);
        start_transmit = 1'b1;
        @(negedge clock);
        start_transmit = 1'b0;
        move_in        = mv(2, 55, 300);
      end
    join
    for (int w = 0; w < 40; w++) begin
      if (tx !== 1'b1 || busy !== 1'b0) tx_bad++;
      @(negedge clock);
    end
    checks++;
    if (tx_bad != 0) begin
      errors++;
      $display("FAIL ignore_no_second_frame: %0d active samples required 0", tx_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, quiet_bad;
    t = 0; quiet_bad = 0;
    send(mv(1, 105, 27), "midreset");
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    repeat (10 * CPB + CPB + 5) @(negedge clock);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_data: tx=%b busy=%b required 0 1", tx, busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || end_transmit !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next_cycle: tx=%b busy=%b end=%b required 1 0 0", tx, busy, end_transmit);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int w = 0; w < 30; w++) begin
      if (tx !== 1'b1 || end_transmit !== 1'b0 || err !== 1'b0 || busy !== 1'b0) quiet_bad++;
      @(negedge clock);
    end
    checks++;
    if (quiet_bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet: %0d bad samples required 0", quiet_bad);
    end
    exp_q = '{8'h42, 8'h41, 8'h39, 8'h39, 8'h5C}; add_newline();
    send(mv(2, 99, 53), "after_reset"); rx_frame("after_reset");
  endtask

  task automatic test_back_to_back();
    exp_q = '{8'h5A, 8'h37, 8'h2B}; add_newline();
    send(mv(0, 7, 26), "b2b_first"); rx_frame("b2b_first");
    exp_q = '{8'h40, 8'h30, 8'h5C}; add_newline();
    send(mv(2, 0, 0), "b2b_second"); rx_frame("b2b_second");
  endtask

  initial begin
    test_reset();
    test_encode();
    test_reject(mv(3, 1, 1), "rej_type3");
    test_reject(mv(0, 1, 703), "rej_col703");
    test_reject(mv(0, 1000, 1), "rej_row1000");
    test_ignore_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
